// File: rtl/code_scan_if.sv
// Request/result bundle between the digit banks, the verifier and lock logic.
// Master supplies banks and requests; slave reports scan progress and result.
interface code_scan_if #(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_W    = 4,
  parameter int MAX_FAILS  = 3
);
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                          start;
  logic                          clear_lock;
  logic [NUM_DIGITS*DIGIT_W-1:0] ui_digits;
  logic [NUM_DIGITS*DIGIT_W-1:0] sp_digits;
  logic                          busy;
  logic                          done;
  logic                          match;
  logic                          locked;
  logic [FCW-1:0]                fail_count;
  logic [IW-1:0]                 scan_idx;
  logic [DIGIT_W-1:0]            scan_digit;

  modport master (
    output start, clear_lock, ui_digits, sp_digits,
    input  busy, done, match, locked,
    input  fail_count, scan_idx, scan_digit
  );

  modport slave (
    input  start, clear_lock, ui_digits, sp_digits,
    output busy, done, match, locked,
    output fail_count, scan_idx, scan_digit
  );
endinterface

// File: rtl/code_scan_verifier.sv
// Snapshots the UI and stored-passcode banks, scans one digit per clock,
// reports match and tracks consecutive failures up to a lockout.
module code_scan_verifier #(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_W    = 4,
  parameter int MAX_FAILS  = 3
) (
  input logic       clk,
  input logic       rst_n,
  code_scan_if.slave bus
);
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESULT,
    LOCKOUT
  } state_t;

  state_t             state;
  logic [DIGIT_W-1:0] ui_snap [NUM_DIGITS];
  logic [DIGIT_W-1:0] sp_snap [NUM_DIGITS];
  logic               mismatch;
  logic               busy;
  logic               done;
  logic               match;
  logic               locked;
  logic [FCW-1:0]     fail_count;
  logic [IW-1:0]      scan_idx;
  logic [DIGIT_W-1:0] scan_digit;

  logic               digit_bad;
  logic [FCW-1:0]     fail_next;

  // A non-BCD digit never matches, even against itself.
  always_comb begin
    digit_bad = (ui_snap[scan_idx] != sp_snap[scan_idx]) ||
                (ui_snap[scan_idx] > DIGIT_W'(9));
    fail_next = (fail_count == FCW'(MAX_FAILS)) ?
                fail_count : fail_count + FCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mismatch   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
      locked     <= 1'b0;
      fail_count <= '0;
      scan_idx   <= '0;
      scan_digit <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        ui_snap[i] <= '0;
        sp_snap[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (bus.clear_lock)
            fail_count <= '0;
          if (bus.start) begin
            state      <= SCAN;
            busy       <= 1'b1;
            match      <= 1'b0;
            mismatch   <= 1'b0;
            scan_idx   <= '0;
            scan_digit <= bus.ui_digits[DIGIT_W-1:0];
            for (int i = 0; i < NUM_DIGITS; i++) begin
              ui_snap[i] <= bus.ui_digits[i*DIGIT_W +: DIGIT_W];
              sp_snap[i] <= bus.sp_digits[i*DIGIT_W +: DIGIT_W];
            end
          end
        end
        SCAN: begin
          if (digit_bad)
            mismatch <= 1'b1;
          if (scan_idx == IW'(NUM_DIGITS - 1)) begin
            state      <= RESULT;
            scan_idx   <= '0;
            scan_digit <= '0;
          end else begin
            scan_idx   <= scan_idx + IW'(1);
            scan_digit <= ui_snap[scan_idx + IW'(1)];
          end
        end
        RESULT: begin
          // busy stays up through the done cycle
          done  <= 1'b1;
          match <= ~mismatch;
          if (!mismatch) begin
            fail_count <= '0;
            state      <= IDLE;
          end else begin
            fail_count <= fail_next;
            if (fail_next == FCW'(MAX_FAILS)) begin
              state  <= LOCKOUT;
              locked <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        LOCKOUT: begin
          busy <= 1'b0;
          if (bus.clear_lock) begin
            fail_count <= '0;
            locked     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.match      = match;
  assign bus.locked     = locked;
  assign bus.fail_count = fail_count;
  assign bus.scan_idx   = scan_idx;
  assign bus.scan_digit = scan_digit;
endmodule

// File: tb/tb_code_scan_verifier.sv
// Bench for code_scan_verifier: timeline model checked every cycle plus
// directed scenarios with literal expectations.
module tb_code_scan_verifier;
  localparam int N    = 8;
  localparam int W    = 4;
  localparam int MAXF = 3;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  code_scan_if #(.NUM_DIGITS(N), .DIGIT_W(W), .MAX_FAILS(MAXF)) bus ();

  code_scan_verifier #(
    .NUM_DIGITS(N),
    .DIGIT_W(W),
    .MAX_FAILS(MAXF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: time since accepted request, result from whole-bank comparison
  bit           m_act;
  int           m_t;
  bit           m_lock;
  bit           m_match;
  int           m_fc;
  logic [W-1:0] su [N];
  logic [W-1:0] ss [N];

  always @(posedge clk or negedge rst_n) begin
    bit ok;
    bit cl;
    if (!rst_n) begin
      m_act = 0; m_t = 0; m_lock = 0; m_match = 0; m_fc = 0;
      for (int i = 0; i < N; i++) begin su[i] = '0; ss[i] = '0; end
    end else begin
      if (m_act) begin
        m_t++;
        if (m_t == N + 1) begin
          ok = 1;
          for (int i = 0; i < N; i++)
            if (su[i] != ss[i] || su[i] > 9) ok = 0;
          m_match = ok;
          if (ok) m_fc = 0;
          else begin
            if (m_fc < MAXF) m_fc++;
            if (m_fc >= MAXF) m_lock = 1;
          end
        end else if (m_t == N + 2) begin
          m_act = 0;
        end
      end
      cl = 0;
      if (!m_act && bus.clear_lock) begin
        cl = m_lock; m_fc = 0; m_lock = 0;
      end
      if (!m_act && !m_lock && !cl && bus.start) begin
        m_act = 1; m_t = 0; m_match = 0;
        for (int i = 0; i < N; i++) begin
          su[i] = bus.ui_digits[i*W +: W];
          ss[i] = bus.sp_digits[i*W +: W];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_busy", bus.busy, m_act);
      check("m_done", bus.done, m_act && m_t == N + 1);
      check("m_match", bus.match, m_match);
      check("m_locked", bus.locked, m_lock);
      check("m_fail_count", bus.fail_count, m_fc);
      check("m_scan_idx", bus.scan_idx,
            (m_act && m_t < N) ? m_t : 0);
      check("m_scan_digit", bus.scan_digit,
            (m_act && m_t < N) ? su[m_t] : 0);
    end
  end

  task automatic run_compare(input logic [31:0] ui,
                             input logic [31:0] sp,
                             input logic [31:0] ui_late,
                             output int lat);
    bus.ui_digits = ui;
    bus.sp_digits = sp;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 3) bus.ui_digits = ui_late;
    end
    check("done_seen", bus.done, 1);
  endtask

  int exp_d [N] = '{2, 1, 9, 3, 5, 4, 8, 8};
  int lat;
  int dq [$];

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.clear_lock = 1'b0;
    bus.ui_digits = '0;
    bus.sp_digits = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_fc", bus.fail_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Matching compare, digit walk
    bus.ui_digits = 32'h8845_3912;
    bus.sp_digits = 32'h8845_3912;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("walk_idx", bus.scan_idx, k);
      check("walk_digit", bus.scan_digit, exp_d[k]);
      @(negedge clk);
    end
    check("walk_pre_done", bus.done, 0);
    check("walk_busy_result", bus.busy, 1);
    @(negedge clk);
    check("walk_done", bus.done, 1);
    check("walk_match", bus.match, 1);
    check("walk_fc", bus.fail_count, 0);
    @(negedge clk);
    check("walk_busy_fall", bus.busy, 0);
    check("walk_done_fall", bus.done, 0);

    // Digit 7 differs; ui changes mid-scan to equal sp
    run_compare(32'h8845_3912, 32'h7845_3912, 32'h7845_3912, lat);
    check("lat9", lat, 9);
    check("snap_match", bus.match, 0);
    check("snap_fc", bus.fail_count, 1);
    @(negedge clk);

    // Reset mid-scan
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_match", bus.match, 0);
    check("arst_locked", bus.locked, 0);
    check("arst_fc", bus.fail_count, 0);
    check("arst_idx", bus.scan_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dq.delete();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done) dq.push_back(c);
    end
    check("arst_no_done", dq.size(), 0);

    // Non-BCD digit in both banks
    run_compare(32'h8845_A912, 32'h8845_A912, 32'h8845_A912, lat);
    check("nbcd_match", bus.match, 0);
    check("nbcd_fc", bus.fail_count, 1);
    run_compare(32'h8845_3912, 32'h0000_0000, 32'h8845_3912, lat);
    check("mm2_fc", bus.fail_count, 2);
    check("mm2_unlocked", bus.locked, 0);
    run_compare(32'h1111_1111, 32'h2222_2222, 32'h1111_1111, lat);
    check("mm3_fc", bus.fail_count, 3);
    @(negedge clk);
    check("lock_set", bus.locked, 1);

    // Lockout ignores start; clear wins over start
    bus.start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("lock_no_busy", bus.busy, 0);
    end
    bus.clear_lock = 1'b1;
    @(negedge clk);
    bus.clear_lock = 1'b0;
    bus.start = 1'b0;
    check("clr_locked", bus.locked, 0);
    check("clr_fc", bus.fail_count, 0);
    check("clr_start_dropped", bus.busy, 0);
    @(negedge clk);
    run_compare(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, lat);
    check("post_clr_match", bus.match, 1);
    @(negedge clk);

    // clear_lock in IDLE zeroes the count
    run_compare(32'h1234_5678, 32'h1234_5679, 32'h1234_5678, lat);
    check("idle_fc1", bus.fail_count, 1);
    @(negedge clk);
    bus.clear_lock = 1'b1;
    @(negedge clk);
    bus.clear_lock = 1'b0;
    check("idle_clr_fc", bus.fail_count, 0);

    // start held high: back-to-back compares
    bus.ui_digits = 32'h0909_0909;
    bus.sp_digits = 32'h0909_0909;
    bus.start = 1'b1;
    dq.delete();
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (bus.done) dq.push_back(c);
    end
    bus.start = 1'b0;
    check("b2b_count", dq.size(), 3);
    if (dq.size() == 3) begin
      check("b2b_first", dq[0], 10);
      check("b2b_gap1", dq[1] - dq[0], N + 2);
      check("b2b_gap2", dq[2] - dq[1], N + 2);
    end
    repeat (12) @(negedge clk);

    // start raised while busy: no restart
    bus.start = 1'b1;
    dq.delete();
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 4) bus.start = 1'b1;
      if (c == 6) bus.start = 1'b0;
      if (bus.done) dq.push_back(c);
    end
    check("busy_start_count", dq.size(), 1);
    if (dq.size() == 1)
      check("busy_start_pos", dq[0], 10);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
